// File: rtl/neuron_layer_scheduler.sv
// ---------------------------------------------------------------------------
// neuron_layer_scheduler
//
// Purpose: time-multiplexes one shared 8-input neuron datapath across the
// NUM_NEURONS neurons of a layer. It takes one 8-beat input vector, fetches
// each neuron's eight weights and bias from a synchronous weight RAM, presents
// the operands to the datapath, captures its 12-bit result and streams the
// results out over a valid/ready handshake.
//
// Optional build macro: SCHED_RELU_EN
//   Defined   -> negative datapath results (bit 11 set) are clamped to zero.
//   Undefined -> the datapath result is passed through unchanged.
//   Timing is identical in both builds.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start                    one-cycle layer request, honoured only in IDLE
//   busy                     high in every state except IDLE
//   x_in, x_valid, x_ready   input-vector beat stream (x_ready only in LOAD_X)
//   w_rd_en, w_addr, w_rdata weight RAM port, data valid the cycle after rd_en
//   n_x, n_w, n_bias         datapath operands (byte k = input/weight k+1)
//   n_out                    datapath result, combinational from the operands
//   out_data, out_idx        neuron result and the index that produced it
//   out_valid, out_ready     result handshake
//   layer_done               one-cycle pulse after the last result is accepted
// ---------------------------------------------------------------------------
module neuron_layer_scheduler #(
    parameter int NUM_NEURONS = 4,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    input  logic [7:0]        x_in,
    input  logic              x_valid,
    output logic              x_ready,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [7:0]        w_rdata,
    output logic [63:0]       n_x,
    output logic [63:0]       n_w,
    output logic [7:0]        n_bias,
    input  logic [11:0]       n_out,
    output logic [11:0]       out_data,
    output logic [3:0]        out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              layer_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_X  = 3'd1;
    localparam logic [2:0] S_FETCH_W = 3'd2;
    localparam logic [2:0] S_WAIT_B  = 3'd3;
    localparam logic [2:0] S_COMPUTE = 3'd4;
    localparam logic [2:0] S_OUTPUT  = 3'd5;

    localparam logic [3:0]        LAST_IDX         = 4'(NUM_NEURONS - 1);
    localparam logic [ADDR_W-1:0] WORDS_PER_NEURON = ADDR_W'(9);

    // Result shaping applied when the datapath output is captured.
    function automatic logic [11:0] shape_result(input logic [11:0] v);
`ifdef SCHED_RELU_EN
        if (v[11]) begin
            shape_result = 12'h000;
        end else begin
            shape_result = v;
        end
`else
        shape_result = v;
`endif
    endfunction

    logic [2:0]        r_state;
    logic [3:0]        r_cnt;
    logic [3:0]        r_idx;
    logic [63:0]       r_n_x;
    logic [63:0]       r_n_w;
    logic [7:0]        r_n_bias;
    logic [11:0]       r_out_data;
    logic [3:0]        r_out_idx;
    logic              r_out_valid;
    logic              r_layer_done;
    logic              r_busy;
    logic              r_x_ready;
    logic              r_w_rd_en;
    logic [ADDR_W-1:0] r_w_addr;

    logic [2:0]        w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic [3:0]        w_idx_nxt;
    logic [63:0]       w_n_x_nxt;
    logic [63:0]       w_n_w_nxt;
    logic [7:0]        w_n_bias_nxt;
    logic [11:0]       w_out_data_nxt;
    logic [3:0]        w_out_idx_nxt;
    logic              w_layer_done_nxt;
    logic              w_rd_en_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;

    // Bit offsets of the byte lanes addressed by the beat / fetch counter.
    // In FETCH_W the read data lags the address by one cycle, so cycle c
    // writes weight byte c-1.
    logic [2:0] w_wt_byte;
    logic [5:0] w_beat_base;
    logic [5:0] w_wt_base;
    assign w_wt_byte   = r_cnt[2:0] - 3'd1;
    assign w_beat_base = {r_cnt[2:0], 3'b000};
    assign w_wt_base   = {w_wt_byte, 3'b000};

    // Next-state, counter and operand-update logic for the layer sequencer.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_idx_nxt        = r_idx;
        w_n_x_nxt        = r_n_x;
        w_n_w_nxt        = r_n_w;
        w_n_bias_nxt     = r_n_bias;
        w_out_data_nxt   = r_out_data;
        w_out_idx_nxt    = r_out_idx;
        w_layer_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD_X;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD_X: begin
                if (x_valid && r_x_ready) begin
                    w_n_x_nxt[w_beat_base +: 8] = x_in;
                    if (r_cnt == 4'd7) begin
                        w_state_nxt = S_FETCH_W;
                        w_cnt_nxt   = 4'd0;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            S_FETCH_W: begin
                if (r_cnt != 4'd0) begin
                    w_n_w_nxt[w_wt_base +: 8] = w_rdata;
                end else begin
                    w_n_w_nxt = r_n_w;
                end
                if (r_cnt == 4'd8) begin
                    w_state_nxt = S_WAIT_B;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_WAIT_B: begin
                // Read data of the ninth fetch address is the bias.
                w_n_bias_nxt = w_rdata;
                w_state_nxt  = S_COMPUTE;
            end
            S_COMPUTE: begin
                w_out_data_nxt = shape_result(n_out);
                w_out_idx_nxt  = r_idx;
                w_state_nxt    = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_layer_done_nxt = 1'b1;
                        w_state_nxt      = S_IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 4'd1;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_FETCH_W;
                    end
                end else begin
                    w_state_nxt = S_OUTPUT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Status/strobe outputs are registered from the next state so that they
    // line up with the state they describe without any output decoding.
    assign w_rd_en_nxt = (w_state_nxt == S_FETCH_W);
    assign w_addr_nxt  = w_rd_en_nxt
                       ? (ADDR_W'(w_idx_nxt) * WORDS_PER_NEURON + ADDR_W'(w_cnt_nxt))
                       : {ADDR_W{1'b0}};

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_idx        <= 4'd0;
            r_n_x        <= 64'd0;
            r_n_w        <= 64'd0;
            r_n_bias     <= 8'd0;
            r_out_data   <= 12'd0;
            r_out_idx    <= 4'd0;
            r_out_valid  <= 1'b0;
            r_layer_done <= 1'b0;
            r_busy       <= 1'b0;
            r_x_ready    <= 1'b0;
            r_w_rd_en    <= 1'b0;
            r_w_addr     <= {ADDR_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_n_x        <= w_n_x_nxt;
            r_n_w        <= w_n_w_nxt;
            r_n_bias     <= w_n_bias_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_idx    <= w_out_idx_nxt;
            r_out_valid  <= (w_state_nxt == S_OUTPUT);
            r_layer_done <= w_layer_done_nxt;
            r_busy       <= (w_state_nxt != S_IDLE);
            r_x_ready    <= (w_state_nxt == S_LOAD_X);
            r_w_rd_en    <= w_rd_en_nxt;
            r_w_addr     <= w_addr_nxt;
        end
    end

    assign busy       = r_busy;
    assign x_ready    = r_x_ready;
    assign w_rd_en    = r_w_rd_en;
    assign w_addr     = r_w_addr;
    assign n_x        = r_n_x;
    assign n_w        = r_n_w;
    assign n_bias     = r_n_bias;
    assign out_data   = r_out_data;
    assign out_idx    = r_out_idx;
    assign out_valid  = r_out_valid;
    assign layer_done = r_layer_done;

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
module tb_neuron_layer_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [7:0]  x_in = 8'd0;
    logic        x_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        busy_a, x_ready_a, w_rd_en_a, out_valid_a, layer_done_a;
    logic [7:0]  w_addr_a, n_bias_a;
    logic [7:0]  w_rdata_a = 8'd0;
    logic [63:0] n_x_a, n_w_a;
    logic [11:0] n_out_a, out_data_a;
    logic [3:0]  out_idx_a;

    logic        busy_b, x_ready_b, w_rd_en_b, out_valid_b, layer_done_b;
    logic [7:0]  w_addr_b, n_bias_b;
    logic [7:0]  w_rdata_b = 8'd0;
    logic [63:0] n_x_b, n_w_b;
    logic [11:0] n_out_b, out_data_b;
    logic [3:0]  out_idx_b;

    logic [7:0]  mem_a [0:255];
    logic [7:0]  mem_b [0:255];
    logic [63:0] lx;
    logic [63:0] lw [0:3];
    logic [7:0]  lb [0:3];
    logic [15:0] sb [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference neuron: low 12 bits of sum(x_i*w_i) + bias.
    function automatic logic [11:0] neuron_f(input logic [63:0] x, input logic [63:0] w,
                                             input logic [7:0] b);
        logic [31:0] acc;
        acc = 32'(b);
        for (int i = 0; i < 8; i++) acc += 32'(x[i*8 +: 8]) * 32'(w[i*8 +: 8]);
        return acc[11:0];
    endfunction

    function automatic logic [11:0] relu_f(input logic [11:0] v);
`ifdef SCHED_RELU_EN
        return v[11] ? 12'h000 : v;
`else
        return v;
`endif
    endfunction

    assign n_out_a = neuron_f(n_x_a, n_w_a, n_bias_a);
    assign n_out_b = neuron_f(n_x_b, n_w_b, n_bias_b);

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (w_rd_en_a) w_rdata_a <= mem_a[w_addr_a];
    always @(posedge clk) if (w_rd_en_b) w_rdata_b <= mem_b[w_addr_b];

    neuron_layer_scheduler #(.NUM_NEURONS(4), .ADDR_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a),
        .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready_a),
        .w_rd_en(w_rd_en_a), .w_addr(w_addr_a), .w_rdata(w_rdata_a),
        .n_x(n_x_a), .n_w(n_w_a), .n_bias(n_bias_a), .n_out(n_out_a),
        .out_data(out_data_a), .out_idx(out_idx_a), .out_valid(out_valid_a),
        .out_ready(out_ready), .layer_done(layer_done_a));

    neuron_layer_scheduler #(.NUM_NEURONS(1), .ADDR_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b),
        .x_in(x_in), .x_valid(x_valid), .x_ready(x_ready_b),
        .w_rd_en(w_rd_en_b), .w_addr(w_addr_b), .w_rdata(w_rdata_b),
        .n_x(n_x_b), .n_w(n_w_b), .n_bias(n_bias_b), .n_out(n_out_b),
        .out_data(out_data_b), .out_idx(out_idx_b), .out_valid(out_valid_b),
        .out_ready(out_ready), .layer_done(layer_done_b));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a();
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 8; i++) mem_a[n*9+i] = lw[n][i*8 +: 8];
            mem_a[n*9+8] = lb[n];
        end
    endtask

    task automatic push_model();
        for (int n = 0; n < 4; n++) sb.push_back({4'(n), relu_f(neuron_f(lx, lw[n], lb[n]))});
    endtask

    // Runs one layer on dut_a; results are checked against the scoreboard.
    task automatic run_layer(input bit gap, input bit hold, input bit extra_start,
                             input bit chk_timing);
        int t0, hs_cnt, budget, bad;
        bit done, stalled, chk_after;
        logic [11:0] hd;
        logic [3:0] hi;
        logic [15:0] e;
        start_a = 1'b1; step(); start_a = 1'b0;
        checks++;
        if (x_ready_a !== 1'b1 || busy_a !== 1'b1) begin
            failures++;
            $display("FAIL load_entry x_ready=%b busy=%b exp 1 1", x_ready_a, busy_a);
        end
        t0 = -1;
        for (int k = 0; k < 8; k++) begin
            if (gap && k > 0) begin x_valid = 1'b0; step(); end
            x_valid = 1'b1; x_in = lx[k*8 +: 8];
            if (t0 < 0) t0 = cyc;
            step();
        end
        x_valid = 1'b0;
        out_ready = 1'b1;
        hs_cnt = 0; budget = 0; done = 1'b0; stalled = 1'b0; chk_after = 1'b0;
        while (!done && budget < 2000) begin
            budget++;
            start_a = (extra_start && budget == 30) ? 1'b1 : 1'b0;
            if (chk_after) begin
                chk_after = 1'b0;
                checks++;
                if (out_valid_a !== 1'b0) begin
                    failures++;
                    $display("FAIL release_once out_valid=%b exp 0", out_valid_a);
                end
            end
            if (hold && !stalled && out_valid_a) begin
                stalled = 1'b1; hd = out_data_a; hi = out_idx_a; out_ready = 1'b0; bad = 0;
                for (int s = 0; s < 20; s++) begin
                    step();
                    if (out_valid_a !== 1'b1 || out_data_a !== hd || out_idx_a !== hi ||
                        w_rd_en_a !== 1'b0) bad++;
                end
                checks++;
                if (bad != 0) begin
                    failures++;
                    $display("FAIL stall_hold bad_cycles=%0d exp 0", bad);
                end
                out_ready = 1'b1; chk_after = 1'b1;
            end
            if (out_valid_a && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL result_extra idx=%0d data=%h exp none", out_idx_a, out_data_a);
                end else begin
                    e = sb.pop_front();
                    if ({out_idx_a, out_data_a} !== e) begin
                        failures++;
                        $display("FAIL result idx=%0d data=%h exp idx=%0d data=%h",
                                 out_idx_a, out_data_a, e[15:12], e[11:0]);
                    end
                end
                if (chk_timing) begin
                    checks++;
                    if (cyc - t0 != 19 + 12*hs_cnt) begin
                        failures++;
                        $display("FAIL result_time n=%0d act=%0d exp=%0d", hs_cnt, cyc - t0,
                                 19 + 12*hs_cnt);
                    end
                end
                hs_cnt++;
            end
            if (layer_done_a) begin
                done = 1'b1;
                if (chk_timing) begin
                    checks++;
                    if (cyc - t0 != 56) begin
                        failures++;
                        $display("FAIL done_time act=%0d exp=56", cyc - t0);
                    end
                end
            end
            if (!done) step();
        end
        start_a = 1'b0;
        checks++;
        if (!done || hs_cnt != 4 || sb.size() != 0) begin
            failures++;
            $display("FAIL layer_end done=%b results=%0d left=%0d exp 1 4 0", done, hs_cnt, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step(); step();
        checks++;
        if ({busy_a, x_ready_a, w_rd_en_a, out_valid_a, layer_done_a} !== 5'd0 ||
            {busy_b, out_valid_b, layer_done_b} !== 3'd0) begin
            failures++;
            $display("FAIL reset_flags act=%b%b%b%b%b exp 00000", busy_a, x_ready_a, w_rd_en_a,
                     out_valid_a, layer_done_a);
        end
        checks++;
        if ({n_x_a, n_w_a, n_bias_a, out_data_a, out_idx_a, w_addr_a} !== 160'd0) begin
            failures++;
            $display("FAIL reset_regs n_x=%h n_w=%h bias=%h data=%h exp 0", n_x_a, n_w_a,
                     n_bias_a, out_data_a);
        end
        rst = 1'b0; step();
    endtask

    task automatic test_reset_mid();
        int bad;
        lx = {8{8'd1}};
        for (int n = 0; n < 4; n++) begin lw[n] = {8{8'(n+3)}}; lb[n] = 8'(n); end
        load_a();
        start_a = 1'b1; step(); start_a = 1'b0;
        for (int k = 0; k < 8; k++) begin x_valid = 1'b1; x_in = 8'(k); step(); end
        x_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        checks++;
        if (w_rd_en_a !== 1'b1) begin
            failures++;
            $display("FAIL mid_fetch w_rd_en=%b exp 1", w_rd_en_a);
        end
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if ({busy_a, w_rd_en_a, out_valid_a, layer_done_a, x_ready_a} !== 5'd0) begin
            failures++;
            $display("FAIL reset_abort act=%b%b%b%b%b exp 00000", busy_a, w_rd_en_a,
                     out_valid_a, layer_done_a, x_ready_a);
        end
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (busy_a || out_valid_a || layer_done_a) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_quiet bad_cycles=%0d exp 0", bad);
        end
        push_model();
        run_layer(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_single();
        int exp_addr, bad_addr, reads, res, dones;
        for (int i = 0; i < 8; i++) mem_b[i] = 8'd2;
        mem_b[8] = 8'd3;
        start_b = 1'b1; step(); start_b = 1'b0;
        for (int k = 0; k < 8; k++) begin x_valid = 1'b1; x_in = 8'd1; step(); end
        x_valid = 1'b0; out_ready = 1'b1;
        exp_addr = 0; bad_addr = 0; reads = 0; res = 0; dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (w_rd_en_b) begin
                if (w_addr_b !== 8'(exp_addr)) bad_addr++;
                exp_addr++; reads++;
            end
            if (out_valid_b && out_ready) begin
                res++;
                checks++;
                if (out_data_b !== 12'h013 || out_idx_b !== 4'd0) begin
                    failures++;
                    $display("FAIL single_result data=%h idx=%0d exp 013 0", out_data_b, out_idx_b);
                end
            end
            if (layer_done_b) dones++;
            step();
        end
        checks++;
        if (reads != 9 || bad_addr != 0) begin
            failures++;
            $display("FAIL single_addr reads=%0d bad=%0d exp 9 0", reads, bad_addr);
        end
        checks++;
        if (res != 1 || dones != 1 || busy_b !== 1'b0) begin
            failures++;
            $display("FAIL single_done results=%0d dones=%0d busy=%b exp 1 1 0", res, dones, busy_b);
        end
    endtask

    task automatic test_four();
        lx = {8{8'd1}};
        for (int n = 0; n < 4; n++) begin lw[n] = {8{8'(n+1)}}; lb[n] = 8'd0; end
        load_a();
        sb.push_back({4'd0, 12'd8});
        sb.push_back({4'd1, 12'd16});
        sb.push_back({4'd2, 12'd24});
        sb.push_back({4'd3, 12'd32});
        run_layer(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++;
        if (layer_done_a !== 1'b0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL done_single_pulse done=%b busy=%b exp 0 0", layer_done_a, busy_a);
        end
    endtask

    task automatic test_stall();
        lx = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
        for (int n = 0; n < 4; n++) begin lw[n] = {8{8'(5*n+1)}}; lb[n] = 8'(10+n); end
        load_a();
        push_model();
        run_layer(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_gapped();
        for (int k = 0; k < 8; k++) lx[k*8 +: 8] = 8'(k+1);
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 8; i++) lw[n][i*8 +: 8] = 8'(n*8+i+1);
            lb[n] = 8'(n+5);
        end
        load_a();
        push_model();
        run_layer(1'b1, 1'b0, 1'b1, 1'b0);
        step();
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL extra_start_ignored busy=%b exp 0", busy_a);
        end
    endtask

    task automatic test_back_to_back();
        lx = {8{8'd3}};
        for (int n = 0; n < 4; n++) begin lw[n] = {8{8'(n+2)}}; lb[n] = 8'(n); end
        load_a();
        push_model();
        run_layer(1'b0, 1'b0, 1'b0, 1'b1);
        step();
        checks++;
        if (busy_a !== 1'b0 || x_ready_a !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle busy=%b x_ready=%b exp 0 0", busy_a, x_ready_a);
        end
        lx = {8{8'd4}};
        for (int n = 0; n < 4; n++) begin lw[n] = {8{8'(3*n+1)}}; lb[n] = 8'(7); end
        load_a();
        push_model();
        run_layer(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_relu();
        lx = {8{8'd2}};
        lw[0] = {8{8'd248}};                                  lb[0] = 8'd0;
        lw[1] = {8'd7, 8'd7, 8'd7, 8'd7, 8'd8, 8'd8, 8'd8, 8'd8}; lb[1] = 8'd7;
        lw[2] = 64'd0;                                         lb[2] = 8'd0;
        lw[3] = {8{8'd255}};                                  lb[3] = 8'd255;
        load_a();
`ifdef SCHED_RELU_EN
        sb.push_back({4'd0, 12'h000});
`else
        sb.push_back({4'd0, 12'hF80});
`endif
        sb.push_back({4'd1, 12'h07F});
        sb.push_back({4'd2, 12'h000});
        sb.push_back({4'd3, 12'h0EF});
        run_layer(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin mem_a[i] = 8'd0; mem_b[i] = 8'd0; end
        test_reset();
        test_reset_mid();
        test_single();
        test_four();
        test_stall();
        test_gapped();
        test_back_to_back();
        test_relu();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neuron_layer_scheduler.md
Name: neuron_layer_scheduler

Overview:
Time-multiplexes one 8-input combinational neuron datapath (8 x 8-bit inputs, 8 x 8-bit weights, 8-bit bias, 12-bit result) across NUM_NEURONS neurons of a layer.
- Accepts one 8-beat input vector.
- Fetches each neuron's 8 weights and bias from a synchronous weight memory.
- Presents the operands to the datapath and captures its result.
- Streams one 12-bit result per neuron out over a valid/ready handshake.

Sits between the layer input stream, the weight RAM, the shared neuron datapath and the next layer.

Parameters:
- NUM_NEURONS, 4, neurons in the layer; legal range 1..16.
- ADDR_W, 8, weight-memory address width; must satisfy 2^ADDR_W >= NUM_NEURONS*9.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to process a layer; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- x_in  in  8  input-vector beat.
- x_valid  in  1  x_in valid.
- x_ready  out  1  high only in LOAD_X.
- w_rd_en  out  1  weight-memory read strobe.
- w_addr  out  ADDR_W  weight-memory address.
- w_rdata  in  8  weight-memory read data; valid the cycle after w_rd_en.
- n_x  out  64  datapath inputs; x1 = [7:0] … x8 = [63:56].
- n_w  out  64  datapath weights, same packing as n_x.
- n_bias  out  8  datapath bias.
- n_out  in  12  datapath result (combinational from n_x/n_w/n_bias).
- out_data  out  12  neuron result.
- out_idx  out  4  index of the neuron that produced out_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- layer_done  out  1  one-cycle pulse on acceptance of the last result.

Behaviour:
- Reset (synchronous, active-high): state IDLE. All outputs, n_x/n_w/n_bias registers and counters = 0.
- rst in any state aborts the layer. No result is emitted and layer_done does not pulse.
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Weight layout: neuron n occupies addresses n*9 .. n*9+8, holding w1..w8 then bias.
- IDLE: start=1 -> LOAD_X with beat counter = 0. start in any other state is ignored.
- LOAD_X:
  - x_ready=1.
  - Each x_valid&&x_ready beat k (k = 0..7) writes n_x byte k.
  - After the 8th beat -> FETCH_W with neuron index = 0.
  - No timeout; the block waits indefinitely for beats.
- FETCH_W (9 cycles, c = 0..8):
  - w_rd_en=1, w_addr = idx*9 + c.
  - In cycles c = 1..8, w_rdata is written to n_w byte c-1.
  - Then -> WAIT_B.
- WAIT_B (1 cycle): w_rd_en=0; w_rdata written to n_bias. -> COMPUTE.
- COMPUTE (1 cycle): operands are stable; n_out is registered into out_data and idx into out_idx. -> OUTPUT.
- OUTPUT:
  - out_valid=1. out_data and out_idx are held stable until out_valid&&out_ready.
  - out_valid never depends combinationally on out_ready.
  - On handshake, if idx == NUM_NEURONS-1: layer_done=1 for the next cycle and -> IDLE.
  - Otherwise idx+1 and -> FETCH_W.
- Latency:
  - First out_valid rises 11 cycles after FETCH_W entry.
  - With out_ready tied high, the layer takes 8 + 12*NUM_NEURONS cycles from the first accepted beat to the layer_done pulse.
- n_x is held for the whole layer. n_w and n_bias change only in FETCH_W and WAIT_B.
- Width rule: out_data equals n_out bit-for-bit (12-bit, no extension or saturation), except as modified by the optional feature.
- Back-to-back layers: start is accepted in the cycle after layer_done; x_ready rises the cycle after that.
- NUM_NEURONS = 1: the last-neuron check is true for idx 0.

Optional Feature:
Macro SCHED_RELU_EN.
- Defined: in COMPUTE, out_data = 12'h000 if n_out[11]==1 (negative two's complement), else n_out.
- Undefined: out_data = n_out unchanged.
- Timing is identical in both builds.

Test Plan:
The bench neuron model computes n_out = low 12 bits of sum(x_i*w_i) + bias.
1. Reset mid-FETCH_W (NUM_NEURONS=4) -> next cycle: IDLE, busy=0, w_rd_en=0, out_valid=0, no layer_done; a fresh start then completes normally.
2. All x=1, all w=2, bias=3, NUM_NEURONS=1, out_ready=1 -> out_data=12'h013, out_idx=0, layer_done pulses once, w_addr sequence 0..8.
3. NUM_NEURONS=4 with neuron n having w=n+1 and bias=0, x all 1, out_ready=1 -> outputs 8,16,24,32 with idx 0..3, one result every 12 cycles, layer_done 8+48 cycles after the first beat.
4. out_ready held low 20 cycles in OUTPUT -> out_valid stays 1, out_data/out_idx unchanged, no weight reads; the release accepts exactly one result.
5. x_valid gapped on alternate cycles plus a start pulse mid-layer -> all 8 beats captured in order, the extra start is ignored, results unchanged.
6. SCHED_RELU_EN defined, n_out=12'hF80 -> out_data=12'h000; n_out=12'h07F -> 12'h07F; undefined build -> 12'hF80 passes through.
